ps2_key_decoder: RTL and testbench

Downstream consumer of the PS/2 frame receiver. Takes validated 8-bit scan-code bytes (set 2), strips the E0/F0 prefixes, tracks modifier and held-key state, translates make codes to ASCII, and queues complete key events in a 4-entry show-ahead FIFO for the display/CPU side. It also keeps a count of distinct key presses for the seven-segment display.

---
 rtl/ps2_key_decoder.sv | 143 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: strips E0/F0 prefixes, tracks modifiers and the held key,
// translates makes to ASCII and queues key events in a show-ahead FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    input  logic       ev_ready_i,
    output logic       ev_valid_o,
    output logic [7:0] ev_code_o,
    output logic       ev_ext_o,
    output logic       ev_break_o,
    output logic       ev_repeat_o,
    output logic [7:0] ev_ascii_o,
    output logic       shift_o,
    output logic       ctrl_o,
    output logic       caps_o,
    output logic [7:0] press_count_o,
    output logic       overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t         state_q, state_d;
    logic           shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d, ovf_q, ovf_d;
    logic           held_v_q, held_v_d;
    logic [8:0]     held_q, held_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]    fill_q, fill_d;
    logic [18:0]    mem_q [FIFO_DEPTH];
    logic [18:0]    word, head;
    logic           is_ctrl, is_pfx, ev, cur_ext, cur_brk, match, rep, is_mod, push, pop;
    logic [7:0]     b;

    // Lowercase/unshifted and shifted characters, modifier state taken before this byte.
    function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh, input logic cp);
        logic [7:0] l, d, s;
        l = 8'h00;
        d = 8'h00;
        s = 8'h00;
        case (c)
            8'h1C: l = "a";   8'h32: l = "b";   8'h21: l = "c";   8'h23: l = "d";
            8'h24: l = "e";   8'h2B: l = "f";   8'h34: l = "g";   8'h33: l = "h";
            8'h43: l = "i";   8'h3B: l = "j";   8'h42: l = "k";   8'h4B: l = "l";
            8'h3A: l = "m";   8'h31: l = "n";   8'h44: l = "o";   8'h4D: l = "p";
            8'h15: l = "q";   8'h2D: l = "r";   8'h1B: l = "s";   8'h2C: l = "t";
            8'h3C: l = "u";   8'h2A: l = "v";   8'h1D: l = "w";   8'h22: l = "x";
            8'h35: l = "y";   8'h1A: l = "z";
            8'h45: begin d = "0"; s = ")"; end
            8'h16: begin d = "1"; s = "!"; end
            8'h1E: begin d = "2"; s = "@"; end
            8'h26: begin d = "3"; s = "#"; end
            8'h25: begin d = "4"; s = "$"; end
            8'h2E: begin d = "5"; s = "%"; end
            8'h36: begin d = "6"; s = "^"; end
            8'h3D: begin d = "7"; s = "&"; end
            8'h3E: begin d = "8"; s = "*"; end
            8'h46: begin d = "9"; s = "("; end
            default: ;
        endcase
        return l != 8'h00 ? ((sh ^ cp) ? l - 8'h20 : l) :
               d != 8'h00 ? (sh ? s : d) :
               c == 8'h29 ? 8'h20 : c == 8'h5A ? 8'h0D : c == 8'h66 ? 8'h08 : 8'h00;
    endfunction

    always_comb begin
        b        = byte_data_i;
        is_ctrl  = b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
        is_pfx   = b == 8'hE0 || b == 8'hF0;
        ev       = byte_valid_i && !is_ctrl && !is_pfx;
        cur_ext  = state_q == EXT || state_q == EXT_BRK;
        cur_brk  = state_q == BRK || state_q == EXT_BRK;
        match    = held_v_q && held_q == {cur_ext, b};
        rep      = !cur_brk && match;
        is_mod   = b == 8'h12 || b == 8'h59 || b == 8'h14 || b == 8'h58;
        state_d  = !byte_valid_i ? state_q :
                   is_ctrl ? IDLE :
                   b == 8'hE0 ? EXT :
                   b == 8'hF0 ? (state_q == IDLE ? BRK : state_q == EXT ? EXT_BRK : state_q) :
                   IDLE;
        shift_d  = ev && (b == 8'h12 || b == 8'h59) ? !cur_brk : shift_q;
        ctrl_d   = ev && b == 8'h14 ? !cur_brk : ctrl_q;
        caps_d   = caps_q ^ (ev && b == 8'h58 && !cur_brk && !match);
        held_v_d = !ev ? held_v_q : cur_brk ? held_v_q && !match : 1'b1;
        held_d   = ev && !cur_brk ? {cur_ext, b} : held_q;
        cnt_d    = cnt_q + 8'(ev && !cur_brk && !match && !is_mod);
        word     = {b, cur_ext, cur_brk, rep,
                    (cur_ext || cur_brk) ? 8'h00 : to_ascii(b, shift_q, caps_q)};
        ev_valid_o = fill_q != '0;
        pop      = ev_valid_o && ev_ready_i;
        push     = ev && (fill_q != FULL_CNT || pop);
        ovf_d    = ovf_q || (ev && !push);
        wr_d     = wr_q + AW'(push);
        rd_d     = rd_q + AW'(pop);
        fill_d   = fill_q + (AW+1)'(push) - (AW+1)'(pop);
        head     = ev_valid_o ? mem_q[rd_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            shift_q  <= 1'b0;
            ctrl_q   <= 1'b0;
            caps_q   <= 1'b0;
            ovf_q    <= 1'b0;
            held_v_q <= 1'b0;
            held_q   <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            ctrl_q   <= ctrl_d;
            caps_q   <= caps_d;
            ovf_q    <= ovf_d;
            held_v_q <= held_v_d;
            held_q   <= held_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !reset_i)
            mem_q[wr_q] <= word;
    end

    assign {ev_code_o, ev_ext_o, ev_break_o, ev_repeat_o, ev_ascii_o} = head;
    assign shift_o       = shift_q;
    assign ctrl_o        = ctrl_q;
    assign caps_o        = caps_q;
    assign press_count_o = cnt_q;
    assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scan-code sequences with hand-computed events.
module tb_ps2_key_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, ev_repeat, shift, ctrl, caps, overflow;
    logic [7:0] ev_code, ev_ascii, press_count;
    int         checks = 0;
    int         failures = 0;

    ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .ev_ready_i(ev_ready), .ev_valid_o(ev_valid), .ev_code_o(ev_code), .ev_ext_o(ev_ext),
        .ev_break_o(ev_break), .ev_repeat_o(ev_repeat), .ev_ascii_o(ev_ascii),
        .shift_o(shift), .ctrl_o(ctrl), .caps_o(caps), .press_count_o(press_count),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bytes sent by consecutive calls arrive on consecutive cycles.
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data = b;
        @(negedge clk);
    endtask

    task automatic idle();
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_ev(input string tag, input logic [7:0] code, input logic ext,
                             input logic brk, input logic rep, input logic [7:0] asc);
        chk({tag, ".valid"}, ev_valid, 1);
        chk({tag, ".event"}, {ev_code, ev_ext, ev_break, ev_repeat, ev_ascii},
            {code, ext, brk, rep, asc});
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst.valid", ev_valid, 0);
        chk("rst.mods", {shift, ctrl, caps}, 0);
        chk("rst.count", press_count, 0);
        chk("rst.ovf", overflow, 0);
        chk("rst.code", ev_code, 0);

        send(8'h1C); send(8'hF0); send(8'h1C); idle();
        chk("t1.count", press_count, 1);
        expect_ev("t1.make", 8'h1C, 0, 0, 0, 8'h61);
        expect_ev("t1.brk", 8'h1C, 0, 1, 0, 8'h00);
        chk("t1.empty", ev_valid, 0);

        send(8'h12); idle();
        chk("t2.shift_on", shift, 1);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); idle();
        chk("t2.shift_off", shift, 0);
        chk("t2.count", press_count, 2);
        expect_ev("t2.shmake", 8'h12, 0, 0, 0, 8'h00);
        expect_ev("t2.A", 8'h1C, 0, 0, 0, 8'h41);
        expect_ev("t2.abrk", 8'h1C, 0, 1, 0, 8'h00);
        expect_ev("t2.shbrk", 8'h12, 0, 1, 0, 8'h00);

        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); idle();
        chk("t3.count", press_count, 3);
        expect_ev("t3.r0", 8'h1C, 0, 0, 0, 8'h61);
        expect_ev("t3.r1", 8'h1C, 0, 0, 1, 8'h61);
        expect_ev("t3.r2", 8'h1C, 0, 0, 1, 8'h61);
        expect_ev("t3.brk", 8'h1C, 0, 1, 0, 8'h00);

        send(8'hE0); send(8'hF0); send(8'h75); idle();
        expect_ev("t4.extbrk", 8'h75, 1, 1, 0, 8'h00);
        chk("t4.single", ev_valid, 0);
        send(8'hE0); send(8'hAA); send(8'h1C); idle();
        expect_ev("t4.ctlbyte", 8'h1C, 0, 0, 0, 8'h61);
        chk("t4.empty", ev_valid, 0);
        chk("t4.count", press_count, 4);

        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); idle();
        chk("t5.no_ovf", overflow, 0);
        send(8'h2C); send(8'h35); idle();
        chk("t5.ovf", overflow, 1);
        chk("t5.count", press_count, 10);
        expect_ev("t5.q", 8'h15, 0, 0, 0, 8'h71);
        expect_ev("t5.w", 8'h1D, 0, 0, 0, 8'h77);
        expect_ev("t5.e", 8'h24, 0, 0, 0, 8'h65);
        expect_ev("t5.r", 8'h2D, 0, 0, 0, 8'h72);
        chk("t5.empty", ev_valid, 0);
        chk("t5.sticky", overflow, 1);

        send(8'h58); send(8'h1C); send(8'h12); send(8'h1C); idle();
        chk("t6.caps", caps, 1);
        chk("t6.shift", shift, 1);
        chk("t6.count", press_count, 12);
        expect_ev("t6.caps", 8'h58, 0, 0, 0, 8'h00);
        expect_ev("t6.A", 8'h1C, 0, 0, 0, 8'h41);
        expect_ev("t6.sh", 8'h12, 0, 0, 0, 8'h00);
        expect_ev("t6.a", 8'h1C, 0, 0, 0, 8'h61);
        send(8'hF0); send(8'h12); idle();
        expect_ev("t6.shbrk", 8'h12, 0, 1, 0, 8'h00);

        send(8'h12); send(8'h1E); send(8'hF0); send(8'h12); send(8'h16); idle();
        expect_ev("t7.sh", 8'h12, 0, 0, 0, 8'h00);
        expect_ev("t7.at", 8'h1E, 0, 0, 0, 8'h40);
        expect_ev("t7.shbrk", 8'h12, 0, 1, 0, 8'h00);
        expect_ev("t7.one", 8'h16, 0, 0, 0, 8'h31);
        chk("t7.count", press_count, 14);

        send(8'hE0); send(8'h14); idle();
        chk("t8.ctrl_on", ctrl, 1);
        send(8'hE0); send(8'hF0); send(8'h14); idle();
        chk("t8.ctrl_off", ctrl, 0);
        expect_ev("t8.mk", 8'h14, 1, 0, 0, 8'h00);
        expect_ev("t8.brk", 8'h14, 1, 1, 0, 8'h00);

        send(8'hE0); idle();
        reset = 1'b1;
        send(8'h1C);
        reset = 1'b0;
        idle();
        chk("t9.empty", ev_valid, 0);
        chk("t9.count", press_count, 0);
        chk("t9.state", {caps, overflow}, 0);
        send(8'h1C); idle();
        chk("t9.count1", press_count, 1);
        expect_ev("t9.plain", 8'h1C, 0, 0, 0, 8'h61);
        chk("t9.done", ev_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
